// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for the 256x16 synchronous RAM.
// Define RAM_ARB_RR_EN for round-robin arbitration; default is fixed priority (A wins).
module ram_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [7:0]  a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_gnt,
    output logic        a_done,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [7:0]  b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_gnt,
    output logic        b_done,
    output logic [15:0] b_rdata,
    output logic [7:0]  ram_addr,
    inout  wire  [15:0] ram_data,
    output logic        ram_ce,
    output logic        ram_oe,
    output logic        ram_we
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD1,
        RD2
    } state_t;

    state_t      state;
    logic [7:0]  addr_q;
    logic [15:0] wdata_q;
    logic        owner_q;
    logic        drive_q;
    logic        pick_b;
    logic        any_req;
    logic        grant;
    logic        sel_we;

`ifdef RAM_ARB_RR_EN
    logic        ptr_q;

    // ptr_q names the favoured port when both request (0 = A, 1 = B)
    always_comb begin
        pick_b = b_req & (~a_req | ptr_q);
    end
`else
    always_comb begin
        pick_b = b_req & ~a_req;
    end
`endif

    always_comb begin
        any_req = a_req | b_req;
        grant   = (state == IDLE) & any_req & ~rst;
        sel_we  = pick_b ? b_we : a_we;
    end

    assign a_gnt    = grant & ~pick_b;
    assign b_gnt    = grant & pick_b;
    assign ram_addr = addr_q;
    assign ram_data = drive_q ? wdata_q : 16'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= 8'h00;
            wdata_q <= 16'h0000;
            owner_q <= 1'b0;
            drive_q <= 1'b0;
            ram_ce  <= 1'b0;
            ram_oe  <= 1'b0;
            ram_we  <= 1'b0;
            a_done  <= 1'b0;
            b_done  <= 1'b0;
            a_rdata <= 16'h0000;
            b_rdata <= 16'h0000;
`ifdef RAM_ARB_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= pick_b;
                        addr_q  <= pick_b ? b_addr : a_addr;
                        wdata_q <= pick_b ? b_wdata : a_wdata;
`ifdef RAM_ARB_RR_EN
                        ptr_q   <= ~pick_b;
`endif
                        ram_ce  <= 1'b1;
                        if (sel_we) begin
                            state   <= WR;
                            ram_we  <= 1'b1;
                            drive_q <= 1'b1;
                        end else begin
                            state   <= RD1;
                            ram_oe  <= 1'b1;
                        end
                    end
                end
                WR: begin
                    state   <= IDLE;
                    ram_ce  <= 1'b0;
                    ram_we  <= 1'b0;
                    drive_q <= 1'b0;
                    a_done  <= ~owner_q;
                    b_done  <= owner_q;
                end
                RD1: begin
                    state <= RD2;
                end
                RD2: begin
                    state  <= IDLE;
                    ram_ce <= 1'b0;
                    ram_oe <= 1'b0;
                    a_done <= ~owner_q;
                    b_done <= owner_q;
                    if (owner_q) begin
                        b_rdata <= ram_data;
                    end else begin
                        a_rdata <= ram_data;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 256x16 synchronous RAM.
// Vector table for single accesses plus hand-written multi-cycle sequences.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_done, b_gnt, b_done;
    logic [15:0] a_rdata, b_rdata;
    logic [7:0]  ram_addr;
    wire  [15:0] ram_data;
    logic        ram_ce, ram_oe, ram_we;

    int checks = 0;
    int errors = 0;
    int viol = 0;

    logic [15:0] mem [256];
    logic [15:0] oreg = 16'h0000;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we)
    );

    // RAM: write at closing edge of a write cycle, output register loads while oe
    always @(posedge clk) begin
        if (ram_ce && ram_we) mem[ram_addr] <= ram_data;
        if (ram_ce && ram_oe) oreg <= mem[ram_addr];
    end
    assign ram_data = (ram_ce && ram_oe) ? oreg : 16'bz;

    always @(negedge clk) begin
        if (ram_oe && (ram_we || ram_data !== oreg)) viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic access(input bit port, input bit we, input logic [7:0] addr,
                          input logic [15:0] wd, input logic [15:0] exp_rd,
                          input string name);
        bit got;
        got = 1'b0;
        if (port) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (port ? b_gnt : a_gnt) got = 1'b1;
            else step();
        end
        chk({name, "_gnt"}, {31'd0, got}, 32'd1);
        step();
        if (port) b_req = 1'b0;
        else a_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (port ? b_done : a_done) got = 1'b1;
            else step();
        end
        chk({name, "_done"}, {31'd0, got}, 32'd1);
        if (!we) chk({name, "_rdata"}, {16'd0, port ? b_rdata : a_rdata}, {16'd0, exp_rd});
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;

    vec_t vt [8];

    initial begin
        bit got;
        bit exp_b;

        vt[0] = '{1'b0, 1'b1, 8'hFF, 16'h1234, 16'h0000};
        vt[1] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 16'h1234};
        vt[2] = '{1'b1, 1'b1, 8'h00, 16'hA5A5, 16'h0000};
        vt[3] = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'hA5A5};
        vt[4] = '{1'b1, 1'b1, 8'h80, 16'h0F0F, 16'h0000};
        vt[5] = '{1'b0, 1'b0, 8'h80, 16'h0000, 16'h0F0F};
        vt[6] = '{1'b0, 1'b1, 8'h80, 16'hF00D, 16'h0000};
        vt[7] = '{1'b1, 1'b0, 8'h80, 16'h0000, 16'hF00D};

        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h55; a_wdata = 16'h1111;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h66; b_wdata = 16'h2222;
        step();
        #1;
        chk("rst_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
        chk("rst_strobes", {29'd0, ram_ce, ram_oe, ram_we}, 32'd0);
        chk("rst_addr", {24'd0, ram_addr}, 32'd0);
        chk("rst_done", {30'd0, a_done, b_done}, 32'd0);
        chk("rst_rdata", {a_rdata, b_rdata}, 32'd0);
        a_req = 1'b0; b_req = 1'b0;
        rst = 1'b0;
        step();

        // A writes 0xBEEF to 0x10, cycle by cycle; fields change after grant
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 16'hBEEF;
        #1;
        chk("wr_c0_gnt", {31'd0, a_gnt}, 32'd1);
        chk("wr_c0_ce", {31'd0, ram_ce}, 32'd0);
        step();
        a_req = 1'b0; a_wdata = 16'h0000; a_addr = 8'h99;
        #1;
        chk("wr_c1_strobes", {29'd0, ram_ce, ram_oe, ram_we}, 32'b101);
        chk("wr_c1_data", {16'd0, ram_data}, 32'h0000BEEF);
        chk("wr_c1_addr", {24'd0, ram_addr}, 32'h10);
        step();
        #1;
        chk("wr_c2_done", {31'd0, a_done}, 32'd1);
        chk("wr_c2_ce", {31'd0, ram_ce}, 32'd0);
        step();
        #1;
        chk("wr_c3_done", {31'd0, a_done}, 32'd0);

        // A reads 0x10
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
        #1;
        chk("rd_c0_gnt", {31'd0, a_gnt}, 32'd1);
        step();
        a_req = 1'b0;
        #1;
        chk("rd_c1_strobes", {29'd0, ram_ce, ram_oe, ram_we}, 32'b110);
        step();
        #1;
        chk("rd_c2_strobes", {29'd0, ram_ce, ram_oe, ram_we}, 32'b110);
        chk("rd_c2_done", {31'd0, a_done}, 32'd0);
        step();
        #1;
        chk("rd_c3_done", {31'd0, a_done}, 32'd1);
        chk("rd_c3_rdata", {16'd0, a_rdata}, 32'h0000BEEF);
        chk("rd_c3_b_rdata", {16'd0, b_rdata}, 32'd0);
        step();

        for (int i = 0; i < 8; i++) begin
            access(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rdata,
                   $sformatf("vec%0d", i));
        end
        chk("a_rdata_hold", {16'd0, a_rdata}, 32'h00000F0F);

        // B write in flight, A read raised during WR
        step();
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'h40; b_wdata = 16'h4444;
        #1;
        chk("bw_gnt", {31'd0, b_gnt}, 32'd1);
        step();
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h40;
        #1;
        chk("bw_wait_gnt", {31'd0, a_gnt}, 32'd0);
        chk("bw_we", {31'd0, ram_we}, 32'd1);
        step();
        #1;
        chk("bw_done_and_a_gnt", {30'd0, b_done, a_gnt}, 32'b11);
        step();
        a_req = 1'b0;
        step();
        step();
        #1;
        chk("ar_done", {31'd0, a_done}, 32'd1);
        chk("ar_rdata", {16'd0, a_rdata}, 32'h00004444);
        step();

        // Both ports held for four writes
        do_reset();
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h30; a_wdata = 16'h1111;
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'h31; b_wdata = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                #1;
                if (a_gnt || b_gnt) got = 1'b1;
                else step();
            end
`ifdef RAM_ARB_RR_EN
            exp_b = (i % 2) == 1;
`else
            exp_b = 1'b0;
`endif
            chk($sformatf("arb%0d_gnt", i), {30'd0, a_gnt, b_gnt}, {30'd0, ~exp_b, exp_b});
            step();
        end
        a_req = 1'b0; b_req = 1'b0;
        step();
        step();

        // Reset during RD1 of a B read
        do_reset();
        access(1'b0, 1'b1, 8'h20, 16'h5A5A, 16'h0000, "pre");
        step();
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20;
        #1;
        chk("rrd_gnt", {31'd0, b_gnt}, 32'd1);
        step();
        b_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("rrd_rd1_oe", {31'd0, ram_oe}, 32'd1);
        step();
        rst = 1'b0;
        #1;
        chk("rrd_idle_strobes", {29'd0, ram_ce, ram_oe, ram_we}, 32'd0);
        chk("rrd_no_done", {31'd0, b_done}, 32'd0);
        chk("rrd_rdata", {16'd0, b_rdata}, 32'd0);
        step();
        #1;
        chk("rrd_no_done2", {31'd0, b_done}, 32'd0);
        step();
        access(1'b1, 1'b0, 8'h20, 16'h0000, 16'h5A5A, "rrd_again");
        step();

        chk("bus_contention", viol, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
